// File: rtl/pwm_pkg.sv
// Shared PWM definitions: current-limit FSM states and the PWM counter terminal value.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LIMIT = 2'd2,
    FAULT = 2'd3
  } pwm_state_e;

  localparam logic [7:0] PWM_LAST_COUNT = 8'hFF;
  localparam logic [4:0] LIMIT_CNT_MAX  = 5'd31;

  function automatic logic [4:0] sat_inc5(input logic [4:0] v);
    return (v == LIMIT_CNT_MAX) ? v : v + 5'd1;
  endfunction

endpackage

// File: rtl/ilimit_ctl_if.sv
// Bundle between the current-limit controller, the PWM stage and the host.
interface ilimit_ctl_if;

  logic       pwmcntce;
  logic [7:0] pwmcount;
  logic       ocin;
  logic       enablereq;
  logic       clearfault;
  logic       currentlimit;
  logic       enablepwm;
  logic       fault;
  logic [4:0] limitcnt;

  modport master (
    output pwmcntce, pwmcount, ocin, enablereq, clearfault,
    input  currentlimit, enablepwm, fault, limitcnt
  );

  modport slave (
    input  pwmcntce, pwmcount, ocin, enablereq, clearfault,
    output currentlimit, enablepwm, fault, limitcnt
  );

endinterface

// File: rtl/oc_filter.sv
// Over-current comparator synchronizer plus run-length filter; trip means the
// synchronized comparator stayed high for FILT_LEN unblanked clocks.
module oc_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ocin,
  input  logic blank,
  output logic trip
);

  localparam int             CW       = $clog2(FILT_LEN + 1);
  localparam logic [CW-1:0]  FILT_MAX = CW'(FILT_LEN);

  logic          sync1;
  logic          ocs;
  logic [CW-1:0] filt_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      ocs   <= 1'b0;
    end else begin
      sync1 <= ocin;
      ocs   <= sync1;
    end
  end

  // Any low sample or blanking window restarts the run; saturating keeps trip steady.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_cnt <= '0;
    end else if (!ocs || blank) begin
      filt_cnt <= '0;
    end else if (filt_cnt != FILT_MAX) begin
      filt_cnt <= filt_cnt + CW'(1);
    end
  end

  assign trip = (filt_cnt == FILT_MAX);

endmodule

// File: rtl/ilimit_ctl.sv
// Cycle-by-cycle current limit controller: blanks, filters and limits each PWM
// period, and latches a fault after FAULT_PERIODS consecutive limited periods.
module ilimit_ctl
  import pwm_pkg::*;
#(
  parameter int BLANK_COUNTS  = 8,
  parameter int FILT_LEN      = 4,
  parameter int FAULT_PERIODS = 16
) (
  input logic         clk,
  input logic         rst_n,
  ilimit_ctl_if.slave bus
);

  pwm_state_e state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic       period_start;
  logic       blank;
  logic       trip;

  assign period_start = bus.pwmcntce && (bus.pwmcount == PWM_LAST_COUNT);
  assign blank        = 32'(bus.pwmcount) < BLANK_COUNTS;

  oc_filter #(.FILT_LEN(FILT_LEN)) u_filter (
    .clk   (clk),
    .rst_n (rst_n),
    .ocin  (bus.ocin),
    .blank (blank),
    .trip  (trip)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Dropping enablereq wins over everything except a latched fault; trip wins over period_start.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.enablereq && period_start) state_d = RUN;
      end
      RUN: begin
        if (!bus.enablereq) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (trip) begin
          state_d = LIMIT;
        end else if (period_start) begin
          cnt_d = '0;
        end
      end
      LIMIT: begin
        if (!bus.enablereq) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (period_start) begin
          cnt_d   = sat_inc5(cnt_q);
          state_d = (cnt_d >= 5'(FAULT_PERIODS)) ? FAULT : RUN;
        end
      end
      FAULT: begin
        if (bus.clearfault) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.enablepwm    = (state_q == RUN)   || (state_q == LIMIT);
  assign bus.currentlimit = (state_q == LIMIT) || (state_q == FAULT);
  assign bus.fault        = (state_q == FAULT);
  assign bus.limitcnt     = cnt_q;

endmodule

// File: tb/tb_ilimit_ctl.sv
// Self-checking bench for ilimit_ctl: directed scenarios plus random stimulus,
// every cycle compared against a behavioural model of the limit rules.
module tb_ilimit_ctl;

  localparam int BLANK  = 8;
  localparam int FILT   = 4;
  localparam int FPER   = 16;
  localparam int MD_OFF = 0;
  localparam int MD_ON  = 1;
  localparam int MD_LIM = 2;
  localparam int MD_FLT = 3;

  logic clk;
  logic rst_n;

  ilimit_ctl_if bus();

  ilimit_ctl #(
    .BLANK_COUNTS  (BLANK),
    .FILT_LEN      (FILT),
    .FAULT_PERIODS (FPER)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit seen_cl  = 1'b0;

  // Reference model: comparator history, run length of qualifying samples, operating mode, period count.
  bit m_hist1, m_hist2;
  int m_run;
  int m_mode;
  int m_cnt;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
  endtask

  task automatic model_reset();
    m_hist1 = 1'b0;
    m_hist2 = 1'b0;
    m_run   = 0;
    m_mode  = MD_OFF;
    m_cnt   = 0;
  endtask

  task automatic model_step();
    bit ps, blk, trp;
    int nrun;
    ps   = bus.pwmcntce && (bus.pwmcount == 8'hFF);
    blk  = int'(bus.pwmcount) < BLANK;
    trp  = (m_run >= FILT);
    nrun = (!m_hist2 || blk) ? 0 : ((m_run + 1 > FILT) ? FILT : m_run + 1);
    case (m_mode)
      MD_OFF: if (bus.enablereq && ps) m_mode = MD_ON;
      MD_ON: begin
        if (!bus.enablereq) begin m_mode = MD_OFF; m_cnt = 0; end
        else if (trp) m_mode = MD_LIM;
        else if (ps) m_cnt = 0;
      end
      MD_LIM: begin
        if (!bus.enablereq) begin m_mode = MD_OFF; m_cnt = 0; end
        else if (ps) begin
          m_cnt  = (m_cnt < 31) ? m_cnt + 1 : 31;
          m_mode = (m_cnt >= FPER) ? MD_FLT : MD_ON;
        end
      end
      default: if (bus.clearfault) begin m_mode = MD_OFF; m_cnt = 0; end
    endcase
    m_hist2 = m_hist1;
    m_hist1 = bus.ocin;
    m_run   = nrun;
  endtask

  // One clock: advance the model with pre-edge inputs, step the PWM counter, compare outputs.
  task automatic applyStimulus();
    model_step();
    @(posedge clk);
    #1;
    if (bus.pwmcntce) bus.pwmcount = bus.pwmcount + 8'd1;
    seen_cl = seen_cl | bus.currentlimit;
    checkOutput("enablepwm",    bus.enablepwm,    int'(m_mode == MD_ON || m_mode == MD_LIM));
    checkOutput("currentlimit", bus.currentlimit, int'(m_mode == MD_LIM || m_mode == MD_FLT));
    checkOutput("fault",        bus.fault,        int'(m_mode == MD_FLT));
    checkOutput("limitcnt",     int'(bus.limitcnt), m_cnt);
  endtask

  task automatic run_to_count(input logic [7:0] target);
    int guard = 0;
    while (bus.pwmcount != target && guard < 1000) begin
      applyStimulus();
      guard++;
    end
    if (guard >= 1000) checkOutput("count_reach", int'(bus.pwmcount), int'(target));
  endtask

  task automatic limited_period(input int idx);
    run_to_count(8'd16);
    bus.ocin = 1'b1;
    run_to_count(8'd240);
    bus.ocin = 1'b0;
    run_to_count(8'hFF);
    applyStimulus();
    checkOutput($sformatf("limited_period_%0d", idx), int'(bus.limitcnt), idx);
  endtask

  task automatic async_reset_check(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput({tag, "_rst_enablepwm"},    bus.enablepwm,    0);
    checkOutput({tag, "_rst_currentlimit"}, bus.currentlimit, 0);
    checkOutput({tag, "_rst_fault"},        bus.fault,        0);
    checkOutput({tag, "_rst_limitcnt"},     int'(bus.limitcnt), 0);
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_fault(input string tag, output int incs);
    int guard = 0;
    int prev  = int'(bus.limitcnt);
    incs = 0;
    while (!bus.fault && guard < 20 * 256) begin
      applyStimulus();
      if (int'(bus.limitcnt) == prev + 1) incs++;
      prev = int'(bus.limitcnt);
      guard++;
    end
    if (guard >= 20 * 256) checkOutput({tag, "_fault_timeout"}, bus.fault, 1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int incs;
    rst_n          = 1'b0;
    bus.pwmcntce   = 1'b0;
    bus.pwmcount   = 8'd0;
    bus.ocin       = 1'b0;
    bus.enablereq  = 1'b0;
    bus.clearfault = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_enablepwm",    bus.enablepwm,    0);
    checkOutput("reset_currentlimit", bus.currentlimit, 0);
    checkOutput("reset_fault",        bus.fault,        0);
    checkOutput("reset_limitcnt",     int'(bus.limitcnt), 0);
    rst_n = 1'b1;

    $display("[TB] enable aligned to period start");
    bus.enablereq = 1'b1;
    bus.pwmcntce  = 1'b1;
    run_to_count(8'hFF);
    checkOutput("enable_before_ff", bus.enablepwm, 0);
    applyStimulus();
    checkOutput("enable_after_ff", bus.enablepwm, 1);
    checkOutput("enable_no_limit", bus.currentlimit, 0);

    $display("[TB] filter length and trip latency");
    run_to_count(8'd20);
    bus.pwmcntce = 1'b0;
    bus.ocin = 1'b1;
    repeat (3) applyStimulus();
    bus.ocin = 1'b0;
    repeat (8) applyStimulus();
    checkOutput("short_pulse_no_limit", bus.currentlimit, 0);
    bus.ocin = 1'b1;
    lat = 0;
    while (!bus.currentlimit && lat < 20) begin
      applyStimulus();
      lat++;
    end
    checkOutput("trip_latency", lat, 7);
    bus.ocin = 1'b0;
    bus.pwmcntce = 1'b1;
    run_to_count(8'hFF);
    checkOutput("limit_held_to_ff", bus.currentlimit, 1);
    applyStimulus();
    checkOutput("limit_clear_after_ff", bus.currentlimit, 0);
    checkOutput("limit_count_one", int'(bus.limitcnt), 1);

    $display("[TB] blanking window");
    seen_cl = 1'b0;
    bus.ocin = 1'b1;
    repeat (8) applyStimulus();
    bus.ocin = 1'b0;
    run_to_count(8'hFF);
    applyStimulus();
    checkOutput("blanked_pulse_ignored", seen_cl, 0);
    checkOutput("clean_period_clears", int'(bus.limitcnt), 0);
    run_to_count(8'd8);
    seen_cl = 1'b0;
    bus.ocin = 1'b1;
    repeat (8) applyStimulus();
    bus.ocin = 1'b0;
    run_to_count(8'hFF);
    checkOutput("unblanked_pulse_limits", seen_cl, 1);
    applyStimulus();
    run_to_count(8'hFF);
    applyStimulus();

    $display("[TB] consecutive period counting and trip at period start");
    for (int p = 1; p <= 5; p++) limited_period(p);
    run_to_count(8'hFF);
    applyStimulus();
    checkOutput("clean_after_five", int'(bus.limitcnt), 0);
    for (int p = 1; p <= 3; p++) limited_period(p);
    run_to_count(8'hF9);
    bus.ocin = 1'b1;
    run_to_count(8'hFF);
    checkOutput("coincide_before", bus.currentlimit, 0);
    applyStimulus();
    bus.ocin = 1'b0;
    checkOutput("coincide_limit", bus.currentlimit, 1);
    checkOutput("coincide_cnt_kept", int'(bus.limitcnt), 3);
    run_to_count(8'hFF);
    applyStimulus();
    run_to_count(8'hFF);
    applyStimulus();

    $display("[TB] fault latch");
    bus.ocin = 1'b1;
    wait_fault("first", incs);
    checkOutput("fault_set", bus.fault, 1);
    checkOutput("fault_no_pwm", bus.enablepwm, 0);
    checkOutput("fault_cnt", int'(bus.limitcnt), FPER);
    checkOutput("fault_increments", incs, FPER);
    for (int i = 0; i < 20; i++) begin
      bus.enablereq = ~bus.enablereq;
      applyStimulus();
    end
    checkOutput("fault_ignores_enreq", bus.fault, 1);
    bus.enablereq  = 1'b1;
    bus.clearfault = 1'b1;
    applyStimulus();
    bus.clearfault = 1'b0;
    checkOutput("clear_fault", bus.fault, 0);
    checkOutput("clear_cnt", int'(bus.limitcnt), 0);
    checkOutput("clear_no_pwm", bus.enablepwm, 0);

    $display("[TB] asynchronous reset in LIMIT and FAULT");
    run_to_count(8'hFF);
    applyStimulus();
    lat = 0;
    while (!bus.currentlimit && lat < 300) begin
      applyStimulus();
      lat++;
    end
    checkOutput("reached_limit", bus.currentlimit, 1);
    async_reset_check("limit");
    wait_fault("second", incs);
    checkOutput("second_fault", bus.fault, 1);
    async_reset_check("fault");

    $display("[TB] random stimulus");
    bus.ocin = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 19) == 0) bus.ocin = ~bus.ocin;
      if ($urandom_range(0, 399) == 0) bus.enablereq = ~bus.enablereq;
      bus.pwmcntce   = ($urandom_range(0, 7) != 0);
      bus.clearfault = ($urandom_range(0, 299) == 0);
      applyStimulus();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
